// File: rtl/fb_access_arbiter_if.sv
// Bundle of MCU, fill-engine and framebuffer-port signals around fb_access_arbiter.
// The master is the IOBUS/MMIO side; the slave is the arbiter that owns the framebuffer port.
interface fb_access_arbiter_if;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        CPU_WE;
    logic        FILL_START;
    logic [6:0]  FILL_X;
    logic [5:0]  FILL_Y;
    logic [6:0]  FILL_W;
    logic [5:0]  FILL_H;
    logic [7:0]  FILL_COLOR;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic        RD_VALID;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        FB_WE;

    modport master (
        output CPU_WA, CPU_WD, CPU_WE,
        output FILL_START, FILL_X, FILL_Y, FILL_W, FILL_H, FILL_COLOR,
        input  FILL_BUSY, FILL_DONE, RD_VALID, FB_WA, FB_WD, FB_WE
    );

    modport slave (
        input  CPU_WA, CPU_WD, CPU_WE,
        input  FILL_START, FILL_X, FILL_Y, FILL_W, FILL_H, FILL_COLOR,
        output FILL_BUSY, FILL_DONE, RD_VALID, FB_WA, FB_WD, FB_WE
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// Framebuffer port arbiter: MCU MMIO accesses at fixed priority over a raster rectangle-fill engine.
//
// state | meaning
// IDLE  | no fill active; FILL_START accepted here only
// RUN   | issuing fill pixels in raster order, stalling on MCU writes
// DONE  | fill finished (or was empty); pulses FILL_DONE, drops FILL_BUSY
module fb_access_arbiter #(
    parameter int H_PIX = 80,
    parameter int V_PIX = 60
) (
    input logic              CLK,
    input logic              RST_N,
    fb_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] H_LIM = 8'(H_PIX);
    localparam logic [7:0] V_LIM = 8'(V_PIX);

    state_t     state;
    logic [6:0] x_cnt;
    logic [5:0] y_cnt;
    logic [6:0] x_start;
    logic [6:0] x_end;
    logic [5:0] y_end;
    logic [7:0] fill_color;

    // Clipped extents are evaluated from the live inputs and captured only on an accepted start.
    logic [7:0] x_sum;
    logic [7:0] y_sum;
    logic [6:0] x_end_c;
    logic [5:0] y_end_c;
    logic       fill_empty;

    always_comb begin
        x_sum      = {1'b0, bus.FILL_X} + {1'b0, bus.FILL_W};
        y_sum      = {2'b00, bus.FILL_Y} + {2'b00, bus.FILL_H};
        x_end_c    = (x_sum > H_LIM) ? H_LIM[6:0] : x_sum[6:0];
        y_end_c    = (y_sum > V_LIM) ? V_LIM[5:0] : y_sum[5:0];
        fill_empty = (bus.FILL_W == 7'd0) || (bus.FILL_H == 6'd0) ||
                     ({1'b0, bus.FILL_X} >= H_LIM) || ({2'b00, bus.FILL_Y} >= V_LIM);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= IDLE;
            x_cnt          <= 7'd0;
            y_cnt          <= 6'd0;
            x_start        <= 7'd0;
            x_end          <= 7'd0;
            y_end          <= 6'd0;
            fill_color     <= 8'd0;
            bus.FB_WE      <= 1'b0;
            bus.FB_WA      <= 13'd0;
            bus.FB_WD      <= 8'd0;
            bus.FILL_BUSY  <= 1'b0;
            bus.FILL_DONE  <= 1'b0;
            bus.RD_VALID   <= 1'b1;
        end else begin
            bus.FILL_DONE <= 1'b0;

            // Port mux: MCU write wins; a fill pixel only takes a slot the MCU left free.
            if (bus.CPU_WE) begin
                bus.FB_WE    <= 1'b1;
                bus.FB_WA    <= bus.CPU_WA;
                bus.FB_WD    <= bus.CPU_WD;
                bus.RD_VALID <= 1'b1;
            end else if (state == RUN) begin
                bus.FB_WE    <= 1'b1;
                bus.FB_WA    <= {y_cnt, x_cnt};
                bus.FB_WD    <= fill_color;
                bus.RD_VALID <= 1'b0;
            end else begin
                bus.FB_WE    <= 1'b0;
                bus.FB_WA    <= bus.CPU_WA;
                bus.RD_VALID <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.FILL_START) begin
                        x_cnt         <= bus.FILL_X;
                        y_cnt         <= bus.FILL_Y;
                        x_start       <= bus.FILL_X;
                        x_end         <= x_end_c;
                        y_end         <= y_end_c;
                        fill_color    <= bus.FILL_COLOR;
                        bus.FILL_BUSY <= 1'b1;
                        state         <= fill_empty ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!bus.CPU_WE) begin
                        if (x_cnt + 7'd1 == x_end) begin
                            x_cnt <= x_start;
                            if (y_cnt + 6'd1 == y_end) begin
                                state <= DONE;
                            end else begin
                                y_cnt <= y_cnt + 6'd1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 7'd1;
                        end
                    end
                end
                DONE: begin
                    bus.FILL_BUSY <= 1'b0;
                    bus.FILL_DONE <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Testbench for fb_access_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a pixel-queue reference model of the arbitration rules.
module tb_fb_access_arbiter;

    logic CLK = 1'b0;
    logic RST_N;

    fb_access_arbiter_if bus();

    fb_access_arbiter #(.H_PIX(80), .V_PIX(60)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #10 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an accepted fill becomes a queue of addresses to be written.
    bit          m_active;
    bit          m_finish;
    logic [12:0] m_q[$];
    logic [7:0]  m_color;
    logic        e_we, e_rdv, e_busy, e_done;
    logic [12:0] e_wa;
    logic [7:0]  e_wd;
    int          fill_writes;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_finish;
        int xe, ye;
        if (!RST_N) begin
            m_q.delete();
            m_active = 0;
            m_finish = 0;
            e_we = 0; e_wa = 13'd0; e_wd = 8'd0; e_rdv = 1;
            e_busy = 0; e_done = 0;
            return;
        end
        was_finish = m_finish;
        e_done = 0;
        if (bus.CPU_WE) begin
            e_we = 1; e_wa = bus.CPU_WA; e_wd = bus.CPU_WD; e_rdv = 1;
        end else if (m_active && !was_finish && m_q.size() > 0) begin
            e_we = 1; e_wa = m_q.pop_front(); e_wd = m_color; e_rdv = 0;
            if (m_q.size() == 0) m_finish = 1;
        end else begin
            e_we = 0; e_wa = bus.CPU_WA; e_rdv = 1;
        end
        if (was_finish) begin
            e_done = 1; e_busy = 0; m_finish = 0; m_active = 0;
        end else if (!m_active && bus.FILL_START) begin
            xe = int'(bus.FILL_X) + int'(bus.FILL_W);
            ye = int'(bus.FILL_Y) + int'(bus.FILL_H);
            if (xe > 80) xe = 80;
            if (ye > 60) ye = 60;
            for (int y = int'(bus.FILL_Y); y < ye; y++)
                for (int x = int'(bus.FILL_X); x < xe; x++)
                    m_q.push_back(13'(y * 128 + x));
            m_color  = bus.FILL_COLOR;
            m_active = 1;
            e_busy   = 1;
            if (m_q.size() == 0) m_finish = 1;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        chk("fb_we", 13'(bus.FB_WE), 13'(e_we));
        chk("fb_wa", bus.FB_WA, e_wa);
        chk("rd_valid", 13'(bus.RD_VALID), 13'(e_rdv));
        chk("fill_busy", 13'(bus.FILL_BUSY), 13'(e_busy));
        chk("fill_done", 13'(bus.FILL_DONE), 13'(e_done));
        if (e_we) chk("fb_wd", 13'(bus.FB_WD), 13'(e_wd));
        if (bus.FB_WE && !bus.RD_VALID) fill_writes++;
    endtask

    task automatic start_fill(input int x, input int y, input int w, input int h, input int c);
        bus.FILL_X = 7'(x); bus.FILL_Y = 6'(y);
        bus.FILL_W = 7'(w); bus.FILL_H = 6'(h);
        bus.FILL_COLOR = 8'(c);
        bus.FILL_START = 1'b1;
        cycle();
        bus.FILL_START = 1'b0;
        // Scramble the parameters to show the running fill uses its latched copy.
        bus.FILL_X = 7'($urandom); bus.FILL_Y = 6'($urandom);
        bus.FILL_W = 7'($urandom); bus.FILL_H = 6'($urandom);
        bus.FILL_COLOR = 8'($urandom);
    endtask

    initial begin
        bus.CPU_WA = 13'h1234; bus.CPU_WD = 8'h55; bus.CPU_WE = 1'b1;
        bus.FILL_START = 1'b0;
        bus.FILL_X = 7'd0; bus.FILL_Y = 6'd0; bus.FILL_W = 7'd0; bus.FILL_H = 6'd0;
        bus.FILL_COLOR = 8'd0;
        RST_N = 1'b0;
        fill_writes = 0;

        // Reset held with a CPU write pending
        cycle();
        cycle();
        RST_N = 1'b1;
        bus.CPU_WE = 1'b0;
        cycle();

        // Single CPU write
        bus.CPU_WA = 13'h0105; bus.CPU_WD = 8'hE0; bus.CPU_WE = 1'b1;
        cycle();
        chk("cpu_wr_we", 13'(bus.FB_WE), 13'd1);
        chk("cpu_wr_wa", bus.FB_WA, 13'h0105);
        bus.CPU_WE = 1'b0;
        cycle();

        // 3x2 fill at (10,5)
        fill_writes = 0;
        start_fill(10, 5, 3, 2, 8'h1C);
        repeat (9) cycle();
        chk("fill3x2_count", 13'(fill_writes), 13'd6);

        // Clipped fill at the bottom-right corner
        fill_writes = 0;
        start_fill(78, 59, 5, 4, 8'hA5);
        repeat (6) cycle();
        chk("clip_count", 13'(fill_writes), 13'd2);

        // Empty fill (x beyond the visible area)
        fill_writes = 0;
        start_fill(80, 3, 4, 4, 8'hFF);
        repeat (4) cycle();
        chk("empty_count", 13'(fill_writes), 13'd0);

        // Contention on the 2nd pixel of a 4x1 fill
        fill_writes = 0;
        start_fill(0, 0, 4, 1, 8'h03);
        cycle();
        bus.CPU_WA = 13'h0ABC; bus.CPU_WD = 8'h77; bus.CPU_WE = 1'b1;
        cycle();
        bus.CPU_WE = 1'b0;
        repeat (6) cycle();
        chk("contend_count", 13'(fill_writes), 13'd4);

        // Abort mid-fill with reset
        start_fill(5, 5, 10, 3, 8'h42);
        repeat (4) cycle();
        RST_N = 1'b0;
        cycle();
        RST_N = 1'b1;
        fill_writes = 0;
        repeat (8) cycle();
        chk("abort_count", 13'(fill_writes), 13'd0);

        // Start during busy is ignored, start after done is accepted
        fill_writes = 0;
        start_fill(20, 10, 5, 1, 8'h11);
        cycle();
        start_fill(30, 30, 6, 2, 8'h22);
        repeat (6) cycle();
        start_fill(40, 40, 2, 2, 8'h33);
        repeat (7) cycle();
        chk("restart_count", 13'(fill_writes), 13'd9);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            RST_N          = ($urandom_range(0, 299) != 0);
            bus.CPU_WE     = ($urandom_range(0, 3) == 0);
            bus.CPU_WA     = 13'($urandom);
            bus.CPU_WD     = 8'($urandom);
            bus.FILL_START = ($urandom_range(0, 5) == 0);
            bus.FILL_X     = 7'($urandom_range(0, 90));
            bus.FILL_Y     = 6'($urandom_range(0, 63));
            bus.FILL_W     = 7'($urandom_range(0, 12));
            bus.FILL_H     = 6'($urandom_range(0, 5));
            bus.FILL_COLOR = 8'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
